// File: rtl/reset_sequencer.sv
// Power-on / software reset sequencer: synchronizes async reset release, enables memories,
// then releases N_DOMAINS active-high resets one step apart; supports timed software reset.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned N_DOMAINS     = 3,
    parameter int unsigned STEP_CYCLES   = 4,
    parameter int unsigned SW_RST_CYCLES = 8
) (
    input  logic                 clk_core,
    input  logic                 async_reset_n,
    input  logic                 sw_reset_req,
    input  logic                 stall,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 mem_en,
    output logic                 imem_en,
    output logic                 seq_done,
    output logic [2:0]           state
);

    localparam int unsigned CNT_MAX = (STEP_CYCLES > SW_RST_CYCLES) ? STEP_CYCLES : SW_RST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(N_DOMAINS + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (N_DOMAINS < 1 || N_DOMAINS > 8) begin : g_bad_dom
        $error("reset_sequencer: N_DOMAINS must be in 1..8");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step
        $error("reset_sequencer: STEP_CYCLES must be >= 1");
    end
    if (SW_RST_CYCLES < 1) begin : g_bad_sw
        $error("reset_sequencer: SW_RST_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_MEM_EN  = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_SW_HOLD = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [N_DOMAINS-1:0]   r_rst;
    logic [N_DOMAINS-1:0]   w_rst_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic                   w_sync_q;
    logic                   w_enter_rel;
    logic                   w_enter_hold;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_core or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_sync  <= '0;
            r_state <= S_SYNC;
            r_rst   <= '1;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], 1'b1};
            r_state <= w_state_nxt;
            r_rst   <= w_rst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rst_nxt    = r_rst;
        w_cnt_nxt    = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        w_idx_nxt    = r_idx;
        w_enter_rel  = 1'b0;
        w_enter_hold = 1'b0;

        case (r_state)
            S_SYNC: begin
                if (w_sync_q) w_state_nxt = S_MEM_EN;
            end
            S_MEM_EN: begin
                w_enter_rel = 1'b1;
            end
            S_RELEASE: begin
                if (sw_reset_req) begin
                    w_enter_hold = 1'b1;
                end else if (r_cnt == CNT_W'(1)) begin
                    for (int unsigned i = 0; i < N_DOMAINS; i++) begin
                        if (IDX_W'(i) == r_idx) w_rst_nxt[i] = 1'b0;
                    end
                    if (r_idx == IDX_W'(N_DOMAINS - 1)) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                        w_cnt_nxt = CNT_W'(STEP_CYCLES);
                    end
                end
            end
            S_RUN: begin
                if (sw_reset_req) w_enter_hold = 1'b1;
            end
            S_SW_HOLD: begin
                if (sw_reset_req) w_cnt_nxt = CNT_W'(SW_RST_CYCLES);
                else if (r_cnt == CNT_W'(1)) w_enter_rel = 1'b1;
            end
            default: begin
                w_state_nxt = S_SYNC;
                w_rst_nxt   = '1;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase

        // Shared entry into the release phase: bit 0 goes now, single domain finishes at once
        if (w_enter_rel) begin
            w_rst_nxt    = '1;
            w_rst_nxt[0] = 1'b0;
            if (N_DOMAINS == 1) begin
                w_state_nxt = S_RUN;
            end else begin
                w_state_nxt = S_RELEASE;
                w_cnt_nxt   = CNT_W'(STEP_CYCLES);
                w_idx_nxt   = IDX_W'(1);
            end
        end
        if (w_enter_hold) begin
            w_state_nxt = S_SW_HOLD;
            w_rst_nxt   = '1;
            w_cnt_nxt   = CNT_W'(SW_RST_CYCLES);
        end
    end

    assign rst_out  = r_rst;
    assign mem_en   = (r_state == S_MEM_EN) || (r_state == S_RELEASE) ||
                      (r_state == S_RUN) || (r_state == S_SW_HOLD);
    assign imem_en  = mem_en & ~stall;
    assign seq_done = (r_state == S_RUN);
    assign state    = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a SYNC_STAGES=3,
// N_DOMAINS=1, STEP_CYCLES=1 instance sharing the clock and async reset.
module tb_reset_sequencer;

    logic       clk_core = 1'b0;
    logic       async_reset_n = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] rst_out;
    logic       mem_en, imem_en, seq_done;
    logic [2:0] state;

    logic       b_sw_reset_req = 1'b0;
    logic       b_stall = 1'b0;
    logic [0:0] b_rst_out;
    logic       b_mem_en, b_imem_en, b_seq_done;
    logic [2:0] b_state;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    always #5 clk_core = ~clk_core;

    reset_sequencer #(
        .SYNC_STAGES(2), .N_DOMAINS(3), .STEP_CYCLES(4), .SW_RST_CYCLES(8)
    ) u_dut (
        .clk_core(clk_core), .async_reset_n(async_reset_n), .sw_reset_req(sw_reset_req),
        .stall(stall), .rst_out(rst_out), .mem_en(mem_en), .imem_en(imem_en),
        .seq_done(seq_done), .state(state)
    );

    reset_sequencer #(
        .SYNC_STAGES(3), .N_DOMAINS(1), .STEP_CYCLES(1), .SW_RST_CYCLES(8)
    ) u_dut_b (
        .clk_core(clk_core), .async_reset_n(async_reset_n), .sw_reset_req(b_sw_reset_req),
        .stall(b_stall), .rst_out(b_rst_out), .mem_en(b_mem_en), .imem_en(b_imem_en),
        .seq_done(b_seq_done), .state(b_state)
    );

    typedef struct {
        int         edge_n;
        logic [2:0] rst;
        logic       men;
        logic       done;
        logic [2:0] st;
        logic       b_rst;
        logic       b_men;
        logic       b_done;
        logic [2:0] b_st;
    } vec_t;

    vec_t boot_vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        edge_cnt++;
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rst"},    32'(rst_out), 32'h7);
        check({tag, "_men"},    32'(mem_en), 32'h0);
        check({tag, "_imem"},   32'(imem_en), 32'h0);
        check({tag, "_done"},   32'(seq_done), 32'h0);
        check({tag, "_state"},  32'(state), 32'h0);
        check({tag, "_b_rst"},  32'(b_rst_out), 32'h1);
        check({tag, "_b_men"},  32'(b_mem_en), 32'h0);
        check({tag, "_b_state"}, 32'(b_state), 32'h0);
    endtask

    // Releases async reset between edges, then walks the boot table.
    task automatic run_boot();
        async_reset_n = 1'b1;
        #1;
        check_reset_state("deassert");
        edge_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            while (edge_cnt < boot_vecs[i].edge_n) step();
            check($sformatf("boot_E%0d_rst", boot_vecs[i].edge_n),   32'(rst_out),   32'(boot_vecs[i].rst));
            check($sformatf("boot_E%0d_men", boot_vecs[i].edge_n),   32'(mem_en),    32'(boot_vecs[i].men));
            check($sformatf("boot_E%0d_done", boot_vecs[i].edge_n),  32'(seq_done),  32'(boot_vecs[i].done));
            check($sformatf("boot_E%0d_state", boot_vecs[i].edge_n), 32'(state),     32'(boot_vecs[i].st));
            check($sformatf("boot_E%0d_brst", boot_vecs[i].edge_n),  32'(b_rst_out), 32'(boot_vecs[i].b_rst));
            check($sformatf("boot_E%0d_bmen", boot_vecs[i].edge_n),  32'(b_mem_en),  32'(boot_vecs[i].b_men));
            check($sformatf("boot_E%0d_bdone", boot_vecs[i].edge_n), 32'(b_seq_done), 32'(boot_vecs[i].b_done));
            check($sformatf("boot_E%0d_bst", boot_vecs[i].edge_n),   32'(b_state),   32'(boot_vecs[i].b_st));
        end
    endtask

    initial begin
        //              edge  rst     men   done  st    brst  bmen  bdone bst
        boot_vecs[0] = '{1,  3'b111, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        boot_vecs[1] = '{2,  3'b111, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        boot_vecs[2] = '{3,  3'b111, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0};
        boot_vecs[3] = '{4,  3'b110, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 3'd1};
        boot_vecs[4] = '{5,  3'b110, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3};
        boot_vecs[5] = '{7,  3'b110, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3};
        boot_vecs[6] = '{8,  3'b100, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3};
        boot_vecs[7] = '{11, 3'b100, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1, 3'd3};
        boot_vecs[8] = '{12, 3'b000, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3};
        boot_vecs[9] = '{13, 3'b000, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3};

        // Power-up reset held for a few edges
        step(); step(); step();
        check_reset_state("por");

        run_boot();

        // Stall gates imem_en combinationally and does not disturb the sequencer
        stall = 1'b1; #1;
        check("stall1_imem", 32'(imem_en), 32'h0);
        check("stall1_men", 32'(mem_en), 32'h1);
        step();
        check("stall1_state", 32'(state), 32'h3);
        check("stall1_rst", 32'(rst_out), 32'h0);
        stall = 1'b0; #1;
        check("stall0_imem", 32'(imem_en), 32'h1);
        stall = 1'b1; #1;
        check("stall2_imem", 32'(imem_en), 32'h0);
        stall = 1'b0; #1;
        check("stall3_imem", 32'(imem_en), 32'h1);

        // Single software reset pulse from RUN
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("sw_R_rst", 32'(rst_out), 32'h7);
        check("sw_R_done", 32'(seq_done), 32'h0);
        check("sw_R_state", 32'(state), 32'h4);
        check("sw_R_men", 32'(mem_en), 32'h1);
        repeat (7) step();
        check("sw_R7_rst", 32'(rst_out), 32'h7);
        check("sw_R7_state", 32'(state), 32'h4);
        step();
        check("sw_R8_rst", 32'(rst_out), 32'h6);
        check("sw_R8_state", 32'(state), 32'h2);
        repeat (4) step();
        check("sw_R12_rst", 32'(rst_out), 32'h4);
        repeat (3) step();
        check("sw_R15_done", 32'(seq_done), 32'h0);
        step();
        check("sw_R16_rst", 32'(rst_out), 32'h0);
        check("sw_R16_done", 32'(seq_done), 32'h1);
        check("sw_R16_state", 32'(state), 32'h3);

        // Second request three edges into SW_HOLD extends the hold
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("ext_R_state", 32'(state), 32'h4);
        repeat (2) step();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        repeat (7) step();
        check("ext_R2p7_rst", 32'(rst_out), 32'h7);
        check("ext_R2p7_state", 32'(state), 32'h4);
        step();
        check("ext_R2p8_rst", 32'(rst_out), 32'h6);
        check("ext_R2p8_state", 32'(state), 32'h2);

        // Abort mid-RELEASE at E6, then re-run the full boot
        async_reset_n = 1'b0; #1;
        check_reset_state("hold_abort");
        step(); step();
        check_reset_state("hold_held");
        run_boot();
        repeat (2) step();
        async_reset_n = 1'b0;
        step(); step();
        run_boot();
        repeat (2) step();
        // Re-run leaves edge 6 in RELEASE; abort there
        async_reset_n = 1'b0;
        step(); step();
        async_reset_n = 1'b1;
        #1;
        edge_cnt = 0;
        while (edge_cnt < 6) step();
        check("abort_E6_pre_state", 32'(state), 32'h2);
        async_reset_n = 1'b0; #1;
        check_reset_state("abort_E6");
        step(); step();
        run_boot();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: reset-deassertion synchronizer depth; legal range >=2.
REQ-002 SHALL have parameter N_DOMAINS, default 3: number of sequenced reset outputs; legal range 1..8.
REQ-003 SHALL have parameter STEP_CYCLES, default 4: clk_core cycles between successive domain releases; legal range >=1.
REQ-004 SHALL have parameter SW_RST_CYCLES, default 8: software-reset hold length in cycles; legal range >=1.
REQ-005 SHALL have port clk_core, input, 1: core clock; all state on its rising edge.
REQ-006 SHALL have port async_reset_n, input, 1: reset, asynchronous, active-low (board reset ANDed with PLL lock upstream).
REQ-007 SHALL have port sw_reset_req, input, 1: synchronous single-cycle software reset request.
REQ-008 SHALL have port stall, input, 1: pipeline stall; gates instruction-memory enable.
REQ-009 SHALL have port rst_out, output, N_DOMAINS: active-high synchronous-release resets; bit 0 is released first.
REQ-010 SHALL have port mem_en, output, 1: data-memory clock enable.
REQ-011 SHALL have port imem_en, output, 1: instruction-memory enable = mem_en AND NOT stall, combinational.
REQ-012 SHALL have port seq_done, output, 1: high while all domains are released.
REQ-013 SHALL have port state, output, 3: FSM state encoding SYNC=0, MEM_EN=1, RELEASE=2, RUN=3, SW_HOLD=4.

Function
REQ-014 SHALL use a SYNC_STAGES-deep flop chain, cleared asynchronously by async_reset_n low and shifting in 1 each edge; its last stage is sync_q.
REQ-015 In SYNC, the FSM SHALL move to MEM_EN on the first edge at which sync_q is sampled 1; mem_en goes 1 on that same edge.
REQ-016 In MEM_EN, the FSM SHALL go to RELEASE on the next edge, deasserting rst_out[0] on that edge and loading the step counter with STEP_CYCLES.
REQ-017 mem_en SHALL therefore lead the rst_out[0] release by exactly one cycle.
REQ-018 In RELEASE, rst_out[i] SHALL deassert exactly STEP_CYCLES edges after rst_out[i-1]; released bits stay 0.
REQ-019 On the edge releasing rst_out[N_DOMAINS-1], the FSM SHALL enter RUN and seq_done SHALL go 1 on that same edge.
REQ-020 With N_DOMAINS=1, RUN and seq_done SHALL be entered on the same edge that releases rst_out[0].
REQ-021 sw_reset_req high in RELEASE or RUN SHALL, on that edge, set all rst_out to 1, clear seq_done, enter SW_HOLD, and load the hold counter with SW_RST_CYCLES; mem_en stays 1.
REQ-022 SW_HOLD SHALL last SW_RST_CYCLES edges, then re-enter RELEASE exactly as in REQ-016, skipping MEM_EN.
REQ-023 sw_reset_req high in SW_HOLD SHALL reload the hold counter to SW_RST_CYCLES; in SYNC and MEM_EN it SHALL be ignored.
REQ-024 Counters SHALL be sized by clog2 of their maximum load and SHALL never wrap; unreachable state codes SHALL go to SYNC on the next edge.
REQ-025 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-026 async_reset_n low SHALL immediately, without a clock, set rst_out to all ones, mem_en=0, imem_en=0, seq_done=0, state=SYNC, and clear the synchronizer chain and counters.
REQ-027 async_reset_n asserted mid-sequence (any state) SHALL abort the sequence per REQ-026; release then restarts from SYNC with full SYNC_STAGES latency.
REQ-028 Release of async_reset_n SHALL take effect only through the synchronizer; no output changes in the cycle of deassertion.

Verification
REQ-029 Defaults; async_reset_n rises before edge E1 -> sync_q=1 at E2; mem_en=1 at E3; rst_out[0]=0 at E4, [1]=0 at E8, [2]=0 and seq_done=1 and state=3 at E12.
REQ-030 In RUN, pulse sw_reset_req for one cycle at edge R -> rst_out=3'b111, seq_done=0, state=4 at R; mem_en stays 1; rst_out[0]=0 at R+8, [2]=0 and seq_done=1 at R+16.
REQ-031 Drop async_reset_n at E6 (mid-RELEASE) -> rst_out=3'b111, mem_en=0, state=0 immediately; re-release reproduces REQ-029 timing.
REQ-032 mem_en=1, toggle stall -> imem_en = NOT stall in the same cycle; stall has no effect on rst_out or state.
REQ-033 Second sw_reset_req 3 cycles into SW_HOLD -> hold extended; rst_out[0] releases 8 edges after the second request.
REQ-034 SYNC_STAGES=3, N_DOMAINS=1, STEP_CYCLES=1 -> mem_en=1 at E4; rst_out[0]=0, seq_done=1, state=3 at E5.
